// File: rtl/eth_tx_frame_arbiter.sv
// Frame-level arbiter: merges NUM_CH byte-wide AXI-Stream sources onto one TX stream.
// Whole frames are granted; the granted channel is passed through combinationally.
module eth_tx_frame_arbiter #(
    parameter int NUM_CH          = 3,
    parameter int CH_W            = $clog2(NUM_CH),
    parameter int PRIO_CH0        = 0,
    parameter int IFG_CYCLES      = 12,
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int CNT_W           = 16
) (
    input  logic                  axi_clk,
    input  logic                  axi_rstn,
    input  logic [NUM_CH*8-1:0]   s_tdata,
    input  logic [NUM_CH-1:0]     s_tvalid,
    input  logic [NUM_CH-1:0]     s_tlast,
    input  logic [NUM_CH-1:0]     s_tuser,
    output logic [NUM_CH-1:0]     s_tready,
    output logic [7:0]            rgmii_tdata,
    output logic                  rgmii_tvalid,
    output logic                  rgmii_tlast,
    output logic                  rgmii_tuser,
    input  logic                  rgmii_tready,
    output logic [CH_W-1:0]       grant_ch,
    output logic                  busy,
    output logic [CNT_W-1:0]      frames_sent,
    output logic [CNT_W-1:0]      frames_trunc
);

    localparam int BC_W     = $clog2(MAX_FRAME_BYTES + 1);
    localparam int GAP_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam int GAP_LAST = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;

    typedef enum logic [1:0] {IDLE, SEND, FLUSH, GAP} state_t;

    localparam state_t END_STATE = (IFG_CYCLES == 0) ? IDLE : GAP;

    state_t             r_state;
    logic [CH_W-1:0]    r_rr_ptr;
    logic [CH_W-1:0]    r_grant_ch;
    logic [BC_W-1:0]    r_byte_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [CNT_W-1:0]   r_frames_sent;
    logic [CNT_W-1:0]   r_frames_trunc;

    logic [7:0]         w_ch_data [NUM_CH];
    logic [CH_W-1:0]    w_sel;
    logic [CH_W:0]      w_idx;
    logic               w_trunc;
    logic               w_g_valid;
    logic               w_g_last;
    logic               w_beat;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign w_ch_data[gi] = s_tdata[gi*8 +: 8];
        end
    endgenerate

    // Scan downwards so the nearest valid channel after rr_ptr wins last.
    always_comb begin
        w_sel = r_rr_ptr;
        w_idx = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_idx = {1'b0, r_rr_ptr} + (CH_W+1)'(k);
            if (w_idx >= (CH_W+1)'(NUM_CH))
                w_idx = w_idx - (CH_W+1)'(NUM_CH);
            if (s_tvalid[w_idx[CH_W-1:0]] && !(PRIO_CH0 != 0 && w_idx == '0))
                w_sel = w_idx[CH_W-1:0];
        end
        if (PRIO_CH0 != 0 && s_tvalid[0])
            w_sel = '0;
    end

    assign w_g_valid = s_tvalid[r_grant_ch];
    assign w_g_last  = s_tlast[r_grant_ch];
    assign w_trunc   = (r_byte_cnt == BC_W'(MAX_FRAME_BYTES - 1));
    assign w_beat    = (r_state == SEND) && w_g_valid && rgmii_tready;

    always_comb begin
        s_tready     = '0;
        rgmii_tdata  = '0;
        rgmii_tvalid = 1'b0;
        rgmii_tlast  = 1'b0;
        rgmii_tuser  = 1'b0;
        case (r_state)
            SEND: begin
                rgmii_tdata            = w_ch_data[r_grant_ch];
                rgmii_tvalid           = w_g_valid;
                rgmii_tlast            = w_g_last | w_trunc;
                rgmii_tuser            = s_tuser[r_grant_ch] | (w_trunc & ~w_g_last);
                s_tready[r_grant_ch]   = rgmii_tready;
            end
            FLUSH: s_tready[r_grant_ch] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (!axi_rstn) begin
            r_state        <= IDLE;
            r_rr_ptr       <= CH_W'(NUM_CH - 1);
            r_grant_ch     <= '0;
            r_byte_cnt     <= '0;
            r_gap_cnt      <= '0;
            r_frames_sent  <= '0;
            r_frames_trunc <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|s_tvalid) begin
                        r_grant_ch <= w_sel;
                        r_rr_ptr   <= w_sel;
                        r_state    <= SEND;
                    end
                end
                SEND: begin
                    if (w_beat) begin
                        if (w_g_last) begin
                            r_frames_sent <= r_frames_sent + 1'b1;
                            r_byte_cnt    <= '0;
                            r_state       <= END_STATE;
                        end else if (w_trunc) begin
                            r_frames_sent  <= r_frames_sent + 1'b1;
                            r_frames_trunc <= r_frames_trunc + 1'b1;
                            r_byte_cnt     <= '0;
                            r_state        <= FLUSH;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end
                // Remainder of a truncated frame is swallowed up to its tlast.
                FLUSH: begin
                    if (w_g_valid && w_g_last)
                        r_state <= END_STATE;
                end
                GAP: begin
                    if (r_gap_cnt == GAP_W'(GAP_LAST)) begin
                        r_gap_cnt <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant_ch     = r_grant_ch;
    assign busy         = (r_state != IDLE);
    assign frames_sent  = r_frames_sent;
    assign frames_trunc = r_frames_trunc;

endmodule
